// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the PC / fetch / decode stage.
// State encoding, default widths and opcode values used downstream.
package pc_fetch_unit_pkg;

    localparam int PC_WIDTH_DEF     = 8;
    localparam int INSTR_WIDTH_DEF  = 16;
    localparam int OPCODE_WIDTH_DEF = 4;

    localparam logic [1:0] WAIT_PC     = 2'd0;
    localparam logic [1:0] WAIT_FETCH  = 2'd1;
    localparam logic [1:0] WAIT_DECODE = 2'd2;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_STOR = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_OUT  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/pc_fetch_unit_next.sv
// Next-PC selection: hold, first-update, pending/bypassed jump, increment.
// A same-cycle jump request is merged in before the priority choice.
module pc_next_logic
    import pc_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                update_en,
    input  logic                latched_hold,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                first_update,
    input  logic                jump_pending,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                first_next,
    output logic                pending_next,
    output logic [PC_WIDTH-1:0] jump_addr_next
);

    logic                eff_pending;
    logic [PC_WIDTH-1:0] eff_addr;

    assign eff_pending = jump_pending | jump_valid;
    assign eff_addr    = jump_valid ? jump_target : jump_addr;

    always_comb begin
        pc_next        = pc;
        first_next     = first_update;
        pending_next   = eff_pending;
        jump_addr_next = eff_addr;
        if (update_en) begin
            priority case (1'b1)
                latched_hold: pc_next = pc;
                first_update: first_next = 1'b0;
                eff_pending: begin
                    pc_next      = eff_addr;
                    pending_next = 1'b0;
                end
                default: pc_next = pc + 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, program memory addressing, instruction capture and decode.
// Driven by one-hot phase triggers; flags out-of-order sequences.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int              PC_WIDTH     = PC_WIDTH_DEF,
    parameter int              INSTR_WIDTH  = INSTR_WIDTH_DEF,
    parameter int              OPCODE_WIDTH = OPCODE_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            latched_hold,
    input  logic                            update_pc_trigger,
    input  logic                            fetch_prog_mem_trigger,
    input  logic                            decode_instr_trigger,
    input  logic                            jump_valid,
    input  logic [PC_WIDTH-1:0]             jump_target,
    output logic [PC_WIDTH-1:0]             prog_mem_addr,
    input  logic [INSTR_WIDTH-1:0]          prog_mem_data,
    output logic [INSTR_WIDTH-1:0]          instr_reg,
    output logic [OPCODE_WIDTH-1:0]         opcode,
    output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] operand,
    output logic                            instr_valid,
    output logic                            seq_error
);

    localparam int OPERAND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;

    logic [1:0]          state;
    logic [PC_WIDTH-1:0] pc;
    logic                first_update;
    logic                jump_pending;
    logic [PC_WIDTH-1:0] jump_addr;

    logic [PC_WIDTH-1:0] pc_next;
    logic                first_next;
    logic                pending_next;
    logic [PC_WIDTH-1:0] jump_addr_next;

    logic multi_trig;
    logic upd_ok;
    logic fetch_ok;
    logic decode_ok;
    logic err_now;

    assign prog_mem_addr = pc;

    assign multi_trig = (update_pc_trigger & fetch_prog_mem_trigger)
                      | (update_pc_trigger & decode_instr_trigger)
                      | (fetch_prog_mem_trigger & decode_instr_trigger);

    assign upd_ok    = update_pc_trigger & ~multi_trig;
    assign fetch_ok  = fetch_prog_mem_trigger & ~multi_trig
                     & (state == WAIT_FETCH);
    assign decode_ok = decode_instr_trigger & ~multi_trig
                     & (state == WAIT_DECODE);

    assign err_now = multi_trig
                   | (update_pc_trigger & (state != WAIT_PC))
                   | (fetch_prog_mem_trigger & (state != WAIT_FETCH))
                   | (decode_instr_trigger & (state != WAIT_DECODE));

    pc_next_logic #(
        .PC_WIDTH(PC_WIDTH)
    ) u_next (
        .update_en      (upd_ok),
        .latched_hold   (latched_hold),
        .pc             (pc),
        .first_update   (first_update),
        .jump_pending   (jump_pending),
        .jump_addr      (jump_addr),
        .jump_valid     (jump_valid),
        .jump_target    (jump_target),
        .pc_next        (pc_next),
        .first_next     (first_next),
        .pending_next   (pending_next),
        .jump_addr_next (jump_addr_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc           <= RESET_VECTOR;
            first_update <= 1'b1;
            jump_pending <= 1'b0;
            jump_addr    <= '0;
        end else begin
            pc           <= pc_next;
            first_update <= first_next;
            jump_pending <= pending_next;
            jump_addr    <= jump_addr_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= WAIT_PC;
            instr_reg   <= '0;
            opcode      <= '0;
            operand     <= '0;
            instr_valid <= 1'b0;
            seq_error   <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            if (err_now)
                seq_error <= 1'b1;
            if (upd_ok)
                state <= WAIT_FETCH;
            if (fetch_ok) begin
                instr_reg <= prog_mem_data;
                state     <= WAIT_DECODE;
            end
            if (decode_ok) begin
                opcode      <= instr_reg[INSTR_WIDTH-1 -: OPCODE_WIDTH];
                operand     <= instr_reg[OPERAND_WIDTH-1:0];
                instr_valid <= ~latched_hold;
                state       <= WAIT_PC;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit with a bench-side ROM.
// Expected words are queued at decode; a monitor checks each valid pulse.
module tb_pc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        latched_hold;
    logic        update_pc_trigger;
    logic        fetch_prog_mem_trigger;
    logic        decode_instr_trigger;
    logic        jump_valid;
    logic [7:0]  jump_target;
    logic [7:0]  prog_mem_addr;
    logic [15:0] prog_mem_data;
    logic [15:0] instr_reg;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        instr_valid;
    logic        seq_error;

    logic [15:0] rom [256];
    logic [15:0] exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    int          m_pc;
    bit          m_first;
    bit          m_pend;
    int          m_jaddr;

    pc_fetch_unit dut (
        .clock                  (clock),
        .reset                  (reset),
        .latched_hold           (latched_hold),
        .update_pc_trigger      (update_pc_trigger),
        .fetch_prog_mem_trigger (fetch_prog_mem_trigger),
        .decode_instr_trigger   (decode_instr_trigger),
        .jump_valid             (jump_valid),
        .jump_target            (jump_target),
        .prog_mem_addr          (prog_mem_addr),
        .prog_mem_data          (prog_mem_data),
        .instr_reg              (instr_reg),
        .opcode                 (opcode),
        .operand                (operand),
        .instr_valid            (instr_valid),
        .seq_error              (seq_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) prog_mem_data <= rom[prog_mem_addr];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [15:0] w;
        forever begin
            @(negedge clock);
            if (instr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_valid: got valid with empty queue");
                end else begin
                    w = exp_q.pop_front();
                    chk("instr_reg", 32'(instr_reg), 32'(w));
                    chk("opcode", 32'(opcode), 32'(w[15:12]));
                    chk("operand", 32'(operand), 32'(w[11:0]));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        m_pc    = 0;
        m_first = 1;
        m_pend  = 0;
        m_jaddr = 0;
    endtask

    // Spec rules for one accepted PC update, with optional same-cycle jump.
    task automatic model_update(input bit hold, input bit byp, input int bt);
        bit p;
        int a;
        p = m_pend | byp;
        a = byp ? bt : m_jaddr;
        if (hold) begin
            m_pend = p; m_jaddr = a;
        end else if (m_first) begin
            m_first = 0; m_pend = p; m_jaddr = a;
        end else if (p) begin
            m_pc = a; m_pend = 0;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    endtask

    task automatic step(input bit u, input bit f, input bit d,
                        input bit jv, input logic [7:0] jt);
        update_pc_trigger      = u;
        fetch_prog_mem_trigger = f;
        decode_instr_trigger   = d;
        jump_valid             = jv;
        jump_target            = jt;
        @(posedge clock);
        #1;
        update_pc_trigger      = 0;
        fetch_prog_mem_trigger = 0;
        decode_instr_trigger   = 0;
        jump_valid             = 0;
        jump_target            = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        latched_hold = 0;
        #1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 0;
    endtask

    task automatic run_seq(input bit hold, input bit byp, input logic [7:0] bt,
                           input bit midj, input logic [7:0] mt);
        logic [15:0] w;
        latched_hold = hold;
        step(1, 0, 0, byp, bt);
        model_update(hold, byp, int'(bt));
        chk("pc", 32'(prog_mem_addr), 32'(m_pc));
        step(0, 0, 0, 0, 8'h0);
        w = rom[m_pc];
        step(0, 1, 0, 0, 8'h0);
        if (!hold) exp_q.push_back(w);
        step(0, 0, 1, midj, mt);
        if (midj) begin
            m_pend  = 1;
            m_jaddr = int'(mt);
        end
        chk("fields", 32'({opcode, operand}), 32'(w));
        step(0, 0, 0, 0, 8'h0);
        latched_hold = 0;
    endtask

    initial begin
        bit h, b, mj;
        reset = 1;
        latched_hold = 0;
        update_pc_trigger = 0;
        fetch_prog_mem_trigger = 0;
        decode_instr_trigger = 0;
        jump_valid = 0;
        jump_target = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_pc", 32'(prog_mem_addr), 32'h0);
        chk("rst_instr", 32'(instr_reg), 32'h0);
        chk("rst_opcode", 32'(opcode), 32'h0);
        chk("rst_operand", 32'(operand), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_err", 32'(seq_error), 32'h0);
        reset = 0;

        rom[0] = 16'hA123;
        run_seq(0, 0, 8'h0, 0, 8'h0);
        chk("err_clean", 32'(seq_error), 32'h0);

        do_reset();
        rom[0] = 16'h1001;
        rom[1] = 16'h2002;
        rom[2] = 16'h3003;
        for (int i = 0; i < 3; i++) run_seq(0, 0, 8'h0, 0, 8'h0);

        run_seq(0, 0, 8'h0, 1, 8'hFF);
        run_seq(0, 0, 8'h0, 0, 8'h0);
        run_seq(0, 0, 8'h0, 0, 8'h0);
        chk("wrap_pc", 32'(prog_mem_addr), 32'h0);

        run_seq(0, 0, 8'h0, 1, 8'h40);
        run_seq(0, 0, 8'h0, 0, 8'h0);
        chk("jump_pc", 32'(prog_mem_addr), 32'h40);
        run_seq(0, 1, 8'h80, 0, 8'h0);
        chk("bypass_pc", 32'(prog_mem_addr), 32'h80);

        run_seq(1, 0, 8'h0, 0, 8'h0);
        chk("hold_pc", 32'(prog_mem_addr), 32'h80);
        run_seq(0, 0, 8'h0, 0, 8'h0);
        chk("resume_pc", 32'(prog_mem_addr), 32'h81);

        for (int i = 0; i < 60; i++) begin
            h  = ($urandom % 6) == 0;
            b  = !h && (($urandom % 5) == 0);
            mj = ($urandom % 5) == 0;
            run_seq(h, b, 8'($urandom), mj, 8'($urandom));
        end
        chk("err_random", 32'(seq_error), 32'h0);

        do_reset();
        step(1, 0, 0, 0, 8'h0);
        model_update(0, 0, 0);
        step(0, 0, 0, 0, 8'h0);
        step(0, 0, 1, 0, 8'h0);
        chk("bad_decode_err", 32'(seq_error), 32'h1);
        chk("bad_decode_op", 32'(opcode), 32'h0);
        chk("bad_decode_ir", 32'(instr_reg), 32'h0);
        exp_q.push_back(rom[m_pc]);
        step(0, 1, 0, 0, 8'h0);
        step(0, 0, 1, 0, 8'h0);
        step(0, 0, 0, 0, 8'h0);
        chk("err_sticky", 32'(seq_error), 32'h1);

        do_reset();
        step(1, 1, 0, 0, 8'h0);
        chk("multi_err", 32'(seq_error), 32'h1);
        run_seq(0, 0, 8'h0, 0, 8'h0);
        run_seq(0, 0, 8'h0, 0, 8'h0);
        chk("multi_pc", 32'(prog_mem_addr), 32'h1);

        step(1, 0, 0, 0, 8'h0);
        step(0, 0, 0, 0, 8'h0);
        step(0, 1, 0, 0, 8'h0);
        reset = 1;
        #1;
        chk("mid_rst_pc", 32'(prog_mem_addr), 32'h0);
        chk("mid_rst_ir", 32'(instr_reg), 32'h0);
        chk("mid_rst_op", 32'({opcode, operand}), 32'h0);
        chk("mid_rst_valid", 32'(instr_valid), 32'h0);
        chk("mid_rst_err", 32'(seq_error), 32'h0);
        @(posedge clock);
        #1;
        reset = 0;
        model_reset();
        run_seq(0, 0, 8'h0, 0, 8'h0);
        chk("post_rst_pc", 32'(prog_mem_addr), 32'h0);

        repeat (3) @(posedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sits directly downstream of the fetch phase sequencer.
- Consumes its one-hot phase triggers (update PC, fetch program memory, decode instruction).
- Owns the program counter, addresses the synchronous program memory, captures the instruction word and presents decoded opcode/operand fields with a one-cycle valid pulse to the execute/output-latch stage.
- Honours the latched hold and pending jumps, and flags out-of-order trigger sequences.

Parameters:
PC_WIDTH, 8, program counter and program memory address width
INSTR_WIDTH, 16, instruction word width
OPCODE_WIDTH, 4, opcode field width (instr_reg MSBs); operand is the remaining LSBs
RESET_VECTOR, 0, PC value after reset; first instruction fetched from here

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
latched_hold  in  1  hold request, already synchronised/latched upstream
update_pc_trigger  in  1  one-cycle phase pulse: advance PC
fetch_prog_mem_trigger  in  1  one-cycle phase pulse: capture memory data
decode_instr_trigger  in  1  one-cycle phase pulse: decode captured word
jump_valid  in  1  one-cycle request to load jump_target at next PC update
jump_target  in  PC_WIDTH  jump destination, sampled when jump_valid=1
prog_mem_addr  out  PC_WIDTH  program memory address (= pc register)
prog_mem_data  in  INSTR_WIDTH  synchronous ROM read data, valid 1 cycle after address
instr_reg  out  INSTR_WIDTH  captured instruction word
opcode  out  OPCODE_WIDTH  decoded opcode, registered
operand  out  INSTR_WIDTH-OPCODE_WIDTH  decoded operand, registered
instr_valid  out  1  one-cycle pulse: opcode/operand newly valid
seq_error  out  1  sticky: trigger sequence violated

Behaviour:
- Reset (async, any time including mid-sequence): pc=RESET_VECTOR, instr_reg=0, opcode=0, operand=0, instr_valid=0, seq_error=0, jump_pending=0, first_update=1, FSM=WAIT_PC. Takes effect immediately, no clock needed.
- prog_mem_addr is driven directly from pc (no extra latency).
- FSM states: WAIT_PC -> WAIT_FETCH -> WAIT_DECODE -> WAIT_PC.
- update_pc_trigger, accepted in any state, moves FSM to WAIT_FETCH. If the state was not WAIT_PC, seq_error is set.
- PC update, priority order:
  - latched_hold=1: pc unchanged, jump_pending retained.
  - first_update=1: pc unchanged (RESET_VECTOR executes first), first_update cleared.
  - jump_pending=1: pc=jump_addr, jump_pending cleared.
  - else: pc=pc+1, wrapping modulo 2^PC_WIDTH (max value -> 0).
- jump_valid in any cycle sets jump_pending=1 and captures jump_addr. A later jump_valid before consumption overwrites it.
- jump_valid in the same cycle as update_pc_trigger: the new target applies at this update (bypass), and jump_pending stays 0.
- fetch_prog_mem_trigger in WAIT_FETCH: instr_reg <= prog_mem_data, FSM -> WAIT_DECODE. The address has been stable at least 1 cycle since the PC update edge, so the data is valid.
- decode_instr_trigger in WAIT_DECODE: opcode <= instr_reg[MSBs], operand <= instr_reg[LSBs], FSM -> WAIT_PC. instr_valid=1 for exactly the next cycle unless latched_hold=1, in which case instr_valid stays 0 while fields still update.
- fetch or decode trigger in the wrong state: ignored (no register change), seq_error set.
- More than one trigger high in the same cycle: all ignored, seq_error set.
- seq_error stays set until reset.
- Sequencer rate is 5 cycles/instruction; no back-pressure exists.

Decomposition:
- Shared package holds:
  - FSM state encoding: WAIT_PC=2'd0, WAIT_FETCH=2'd1, WAIT_DECODE=2'd2.
  - PC_WIDTH/INSTR_WIDTH/OPCODE_WIDTH defaults.
  - Opcode constants used downstream.
- One natural sub-module, pc_next_logic: combinational next-PC selection (hold/first/jump/increment, wrap).
- FSM, instruction register and decode registers stay in pc_fetch_unit.

Test Plan:
- Reset, then 5-cycle trigger sequence with ROM[0]=16'hA123 -> prog_mem_addr=0, instr_reg=16'hA123, opcode=4'hA, operand=12'h123, one instr_valid pulse, seq_error=0.
- Three full sequences, ROM[0..2]=16'h1001,16'h2002,16'h3003 -> addresses 0,1,2, opcodes 1,2,3 in order.
- PC_WIDTH=8, pc=8'hFF, next update -> pc=8'h00, ROM[0] fetched.
- jump_valid with jump_target=8'h40 mid-decode -> next update gives pc=8'h40. Same-cycle jump_valid with update -> pc=target that cycle.
- latched_hold=1 across one sequence -> pc unchanged, instr_valid stays 0. Release -> normal increment resumes.
- decode_instr_trigger in WAIT_FETCH -> ignored, seq_error=1 sticky. Assert reset mid-WAIT_DECODE -> all outputs at reset values immediately, pc=RESET_VECTOR.
